// File: rtl/clk_freq_meter_if.sv
// Handshake and result bundle between a measurement requester (master) and clk_freq_meter (slave).
// o_match exists only when CLK_FREQ_METER_CHECK_EN is defined.
interface clk_freq_meter_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 i_start;
  logic                 o_busy;
  logic                 o_valid;
  logic                 o_timeout;
  logic [CNT_WIDTH-1:0] o_period;
  logic [CNT_WIDTH-1:0] o_high;
`ifdef CLK_FREQ_METER_CHECK_EN
  logic                 o_match;

  modport master (output i_start, input o_busy, o_valid, o_timeout, o_period, o_high, o_match);
  modport slave  (input i_start, output o_busy, o_valid, o_timeout, o_period, o_high, o_match);
`else
  modport master (output i_start, input o_busy, o_valid, o_timeout, o_period, o_high);
  modport slave  (input i_start, output o_busy, o_valid, o_timeout, o_period, o_high);
`endif
endinterface

// File: rtl/clk_freq_meter.sv
// Measures period and high time of a slow clock-like signal in i_clk_FPGA cycles, with timeout.
// Optional macro CLK_FREQ_METER_CHECK_EN adds o_match against the expected FRECUENCY_IN/FRECUENCY_OUT shape.
module clk_freq_meter #(
  parameter int FRECUENCY_IN   = 20,
  parameter int FRECUENCY_OUT  = 5,
  parameter int CNT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TOLERANCE      = 1
) (
  input  logic          i_clk_FPGA,
  input  logic          i_reset,
  input  logic          i_sig,
  clk_freq_meter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_MEASURE = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_TIMEOUT  = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_ARM_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  // Nonsensical configurations show up as this named marker in the elaborated hierarchy.
  if ((FRECUENCY_OUT < 1) || (FRECUENCY_IN < FRECUENCY_OUT) || (TOLERANCE < 0) ||
      (TIMEOUT_CYCLES < 2)) begin : g_cfg_suspect
  end

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_sync1, r_sync2, r_prev;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_valid, w_valid_nxt;
  logic                 r_timeout, w_timeout_nxt;
  logic [CNT_WIDTH-1:0] r_period, w_period_nxt;
  logic [CNT_WIDTH-1:0] r_high, w_high_nxt;
  logic                 r_fall_seen, w_fall_seen_nxt;
  logic                 w_rise, w_fall;
  logic [CNT_WIDTH-1:0] w_high_done;

  assign w_rise      = r_sync2 & ~r_prev;
  assign w_fall      = ~r_sync2 & r_prev;
  // Without a falling edge inside the period the high time degenerates to the full period.
  assign w_high_done = r_fall_seen ? r_high : r_cnt;
  assign w_busy_nxt  = (w_state_nxt == S_ARM) || (w_state_nxt == S_MEASURE);

`ifdef CLK_FREQ_METER_CHECK_EN
  localparam int EXP_PERIOD = 2 * ((FRECUENCY_IN / FRECUENCY_OUT) / 2);
  localparam int EXP_HIGH   = (FRECUENCY_IN / FRECUENCY_OUT) / 2;

  logic r_match, w_match_nxt;

  function automatic logic f_within_tol(input logic [CNT_WIDTH-1:0] a,
                                        input logic [CNT_WIDTH-1:0] b);
    logic [CNT_WIDTH-1:0] diff;
    diff = (a >= b) ? (a - b) : (b - a);
    return diff <= CNT_WIDTH'(TOLERANCE);
  endfunction

  assign bus.o_match = r_match;
`endif

  // Input synchronizer plus edge-history flop.
  always_ff @(posedge i_clk_FPGA or posedge i_reset) begin
    if (i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_sig;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Next-state and result computation.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_valid_nxt     = r_valid;
    w_timeout_nxt   = r_timeout;
    w_period_nxt    = r_period;
    w_high_nxt      = r_high;
    w_fall_seen_nxt = r_fall_seen;
`ifdef CLK_FREQ_METER_CHECK_EN
    w_match_nxt     = r_match;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.i_start) begin
          w_state_nxt     = S_ARM;
          w_cnt_nxt       = {CNT_WIDTH{1'b0}};
          w_valid_nxt     = 1'b0;
          w_timeout_nxt   = 1'b0;
          w_period_nxt    = {CNT_WIDTH{1'b0}};
          w_high_nxt      = {CNT_WIDTH{1'b0}};
          w_fall_seen_nxt = 1'b0;
`ifdef CLK_FREQ_METER_CHECK_EN
          w_match_nxt     = 1'b0;
`endif
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ARM: begin
        if (w_rise) begin
          w_state_nxt = S_MEASURE;
          w_cnt_nxt   = CNT_WIDTH'(1);
        end else if (r_cnt == CNT_ARM_LAST) begin
          w_state_nxt   = S_IDLE;
          w_timeout_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
        end
      end
      S_MEASURE: begin
        if (w_rise) begin
          w_state_nxt  = S_IDLE;
          w_period_nxt = r_cnt;
          w_high_nxt   = w_high_done;
          w_valid_nxt  = 1'b1;
`ifdef CLK_FREQ_METER_CHECK_EN
          w_match_nxt  = f_within_tol(r_cnt, CNT_WIDTH'(EXP_PERIOD)) &&
                         f_within_tol(w_high_done, CNT_WIDTH'(EXP_HIGH));
`endif
        end else if (r_cnt == CNT_TIMEOUT) begin
          w_state_nxt   = S_IDLE;
          w_timeout_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
          if (w_fall && !r_fall_seen) begin
            w_high_nxt      = r_cnt;
            w_fall_seen_nxt = 1'b1;
          end else begin
            w_fall_seen_nxt = r_fall_seen;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk_FPGA or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counter and registered outputs.
  always_ff @(posedge i_clk_FPGA or posedge i_reset) begin
    if (i_reset) begin
      r_cnt       <= {CNT_WIDTH{1'b0}};
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_timeout   <= 1'b0;
      r_period    <= {CNT_WIDTH{1'b0}};
      r_high      <= {CNT_WIDTH{1'b0}};
      r_fall_seen <= 1'b0;
`ifdef CLK_FREQ_METER_CHECK_EN
      r_match     <= 1'b0;
`endif
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_busy      <= w_busy_nxt;
      r_valid     <= w_valid_nxt;
      r_timeout   <= w_timeout_nxt;
      r_period    <= w_period_nxt;
      r_high      <= w_high_nxt;
      r_fall_seen <= w_fall_seen_nxt;
`ifdef CLK_FREQ_METER_CHECK_EN
      r_match     <= w_match_nxt;
`endif
    end
  end

  assign bus.o_busy    = r_busy;
  assign bus.o_valid   = r_valid;
  assign bus.o_timeout = r_timeout;
  assign bus.o_period  = r_period;
  assign bus.o_high    = r_high;

endmodule
